// File: rtl/osc_seq_pkg.sv
// Shared types and constants for the oscillator bank sequencer.
package osc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SWEEP,
    SAVE
  } state_e;

  localparam logic [11:0] COMP_UNITY = 12'd4095;
  localparam int          OVR_CNT_W  = 16;

endpackage

// File: rtl/osc_seq_bin_counter.sv
// Gain RAM bin address counter: loads FIRST_BIN, increments on request and
// parks on LAST_BIN, which it flags through last_o.
module osc_seq_bin_counter #(
  parameter int AW        = 10,
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 2**AW-1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] FIRST_A = AW'(FIRST_BIN);
  localparam logic [AW-1:0] LAST_A  = AW'(LAST_BIN);

  assign last_o = (addr_o == LAST_A);

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      addr_o <= '0;
    end else if (load_i) begin
      addr_o <= FIRST_A;
    end else if (inc_i && !last_o) begin
      addr_o <= addr_o + 1'b1;
    end
  end

endmodule

// File: rtl/osc_bank_sequencer.sv
// Sweeps bins FIRST_BIN..LAST_BIN once per accepted sample tick and drives the
// accumulator strobes aligned with the 1-cycle gain RAM read data.
// Optional build macro OSC_SEQ_OVERRUN_CNT_EN adds a saturating overrun counter.
module osc_bank_sequencer
  import osc_seq_pkg::*;
#(
  parameter int AW        = 10,
  parameter int FCW       = 10,
  parameter int FIRST_BIN = 1,
  parameter int LAST_BIN  = 2**AW-1
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 enable_i,
  input  logic                 sample_tick_i,
  input  logic [11:0]          compression_i,
  output logic [AW-1:0]        gain_rd_addr_o,
  output logic                 gain_rd_en_o,
  output logic                 accumulate_o,
  output logic                 save_o,
  output logic [AW-1:0]        freq_number_o,
  output logic [FCW-1:0]       frame_counter_o,
  output logic [11:0]          compression_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [OVR_CNT_W-1:0] overrun_cnt_o
);

  localparam logic [AW-1:0] LAST_A = AW'(LAST_BIN);

  state_e state_q;
  logic   accept;
  logic   dropped;
  logic   addr_last;

  assign accept  = (state_q == IDLE) && sample_tick_i && enable_i;
  assign dropped = sample_tick_i && busy_o;

  osc_seq_bin_counter #(
    .AW        (AW),
    .FIRST_BIN (FIRST_BIN),
    .LAST_BIN  (LAST_BIN)
  ) u_bin_counter (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .load_i (accept),
    .inc_i  (gain_rd_en_o && (state_q == PRIME || state_q == SWEEP)),
    .addr_o (gain_rd_addr_o),
    .last_o (addr_last)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q         <= IDLE;
      gain_rd_en_o    <= 1'b0;
      accumulate_o    <= 1'b0;
      save_o          <= 1'b0;
      busy_o          <= 1'b0;
      overrun_o       <= 1'b0;
      freq_number_o   <= '0;
      frame_counter_o <= '0;
      compression_o   <= COMP_UNITY;
    end else begin
      if (dropped) overrun_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            compression_o <= compression_i;
            gain_rd_en_o  <= 1'b1;
            busy_o        <= 1'b1;
            state_q       <= PRIME;
          end
        end
        PRIME: begin
          gain_rd_en_o  <= !addr_last;
          accumulate_o  <= 1'b1;
          freq_number_o <= gain_rd_addr_o;
          state_q       <= SWEEP;
        end
        SWEEP: begin
          // freq_number_o trails the issued address by the RAM latency.
          if (freq_number_o == LAST_A) begin
            accumulate_o <= 1'b0;
            save_o       <= 1'b1;
            state_q      <= SAVE;
          end else begin
            freq_number_o <= gain_rd_addr_o;
            gain_rd_en_o  <= gain_rd_en_o && !addr_last;
          end
        end
        SAVE: begin
          save_o          <= 1'b0;
          busy_o          <= 1'b0;
          frame_counter_o <= frame_counter_o + 1'b1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OSC_SEQ_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovr_cnt_q <= '0;
    end else if (dropped && (ovr_cnt_q != '1)) begin
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
`else
  assign overrun_cnt_o = '0;
`endif

endmodule
